key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL expose parameter NUM_KEYS, default 4, number of independent key channels (1..8).
REQ-002 The block SHALL expose parameter CLK_FREQ_HZ, default 25_000_000, clk frequency.
REQ-003 The block SHALL expose parameter DEBOUNCE_US, default 20_000, stable time required to accept a press or release.
REQ-004 The block SHALL expose parameter LONG_US, default 1_000_000, hold time for a long-press event.
REQ-005 The block SHALL have port clk  input  1  system clock.
REQ-006 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port key_n  input  NUM_KEYS  raw asynchronous key pins, low = pressed.
REQ-008 The block SHALL have port key_state  output  NUM_KEYS  debounced level, 1 = held.
REQ-009 The block SHALL have port key_press  output  NUM_KEYS  one-cycle pulse per accepted press.
REQ-010 The block SHALL have port key_release  output  NUM_KEYS  one-cycle pulse per accepted release.
REQ-011 The block SHALL have port key_long  output  NUM_KEYS  one-cycle pulse when a hold reaches LONG_CYC.
REQ-012 The block SHALL have port key_valid  output  1  OR of key_press, same cycle.
REQ-013 The block SHALL have port key_code  output  3  index of the lowest-numbered bit set in key_press; 0 when key_valid=0.

Function
REQ-014 DEBOUNCE_CYC SHALL equal CLK_FREQ_HZ/1_000_000*DEBOUNCE_US, and LONG_CYC SHALL equal CLK_FREQ_HZ/1_000_000*LONG_US; both SHALL be at least 2.
REQ-015 Each key_n bit SHALL pass through a 2-flop synchronizer; the FSM SHALL see only the second flop output (ks).
REQ-016 Each channel FSM SHALL have states IDLE, PRESS_DB, HELD, REL_DB.
REQ-017 In IDLE, ks=0 SHALL move to PRESS_DB with the debounce counter cleared.
REQ-018 In PRESS_DB, ks=1 SHALL return to IDLE with no output event (bounce reject).
REQ-019 In PRESS_DB, when ks=0 and the counter equals DEBOUNCE_CYC-1, the FSM SHALL move to HELD, pulse key_press, and clear the hold counter.
REQ-020 Otherwise in PRESS_DB, the counter SHALL increment.
REQ-021 Latency: with edge 0 being the first edge sampling key_n low and no bounce, key_press SHALL be high for exactly one cycle after edge DEBOUNCE_CYC+2.
REQ-022 In HELD, ks=1 SHALL move to REL_DB with the debounce counter cleared.
REQ-023 In HELD, the hold counter SHALL increment, pulse key_long once on reaching LONG_CYC-1, then saturate with no further key_long until the next press.
REQ-024 In REL_DB, ks=0 SHALL return to HELD with the hold counter preserved.
REQ-025 In REL_DB, when ks=1 and the counter equals DEBOUNCE_CYC-1, the FSM SHALL move to IDLE and pulse key_release; the hold counter SHALL pause in REL_DB.
REQ-026 key_state SHALL be 1 in HELD and REL_DB, and 0 in IDLE and PRESS_DB.
REQ-027 All outputs SHALL be registered; channels SHALL be fully independent, and simultaneous presses SHALL set multiple key_press bits in the same cycle.
REQ-028 A key_long pulse and a REL_DB entry occurring in the same cycle SHALL both take effect (the long pulse is not lost).

Reset
REQ-029 On rst_n low, synchronizer flops SHALL be set to 1, FSMs SHALL be in IDLE, counters SHALL be 0, and all outputs SHALL be 0, asynchronously.
REQ-030 Reset asserted mid-press SHALL discard the event: no key_release after rst_n deasserts; a key still held then SHALL be re-debounced from IDLE.

Structure
REQ-031 DEBOUNCE_CYC/LONG_CYC derivation, the FSM state encoding (2-bit), and counter width $clog2(LONG_CYC) SHALL live in shared package key_pkg.
REQ-032 One sub-module key_debounce_ch (synchronizer, FSM, counters for one key) SHALL be instantiated NUM_KEYS times; the top SHALL hold only the key_valid/key_code encoding.

Verification (CLK_FREQ_HZ=1_000_000, DEBOUNCE_US=8, LONG_US=40)
REQ-033 Clean press on key 0 at edge 0 -> key_press[0] one cycle after edge 10, key_valid=1, key_code=0, key_state[0]=1 from the same cycle.
REQ-034 key 1 low for 5 cycles then high, repeated 3 times -> no key_press, key_state[1] stays 0.
REQ-035 Key 2 held 60 cycles then released cleanly -> exactly one key_long[2] (40 cycles after key_press[2]), one key_release[2] 10 cycles after the release edge.
REQ-036 Keys 1 and 3 pressed the same edge -> key_press=4'b1010 for one cycle, key_code=1.
REQ-037 A 3-cycle high glitch during hold on key 0 -> no key_release, key_state[0] stays 1.
REQ-038 rst_n pulsed low while key 0 is in HELD, key kept low -> outputs 0 during reset, then a fresh key_press[0] 10 cycles after rst_n rises, with no key_release.

Source files
------------

// File: rtl/key_pkg.sv
// +----------------------------------------------------------------------+
// | key_pkg: shared constants, state encoding and cycle-count helpers    |
// | for the key debouncer.                                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package key_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_PRESS_DB = 2'd1;
  localparam state_t ST_HELD     = 2'd2;
  localparam state_t ST_REL_DB   = 2'd3;

  // Whole-MHz clock times microseconds gives the cycle count.
  function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    return (clk_hz / 1_000_000) * us;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned cyc);
    return (cyc < 2) ? 1 : $clog2(cyc);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce_ch.sv
// +----------------------------------------------------------------------+
// | key_debounce_ch: one key channel - synchronizer, debounce FSM, hold  |
// | counter and registered press/release/long events.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 2,
  parameter int unsigned LONG_CYC     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic press_nxt_o
);

  localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYC);
  localparam int unsigned HOLD_W = cnt_width(LONG_CYC);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

  logic [1:0]        sync_q;
  logic              ks;
  state_t            state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_done_q, long_done_d;
  logic              lvl_q, lvl_d;
  logic              press_q, press_d;
  logic              rel_q, rel_d;
  logic              long_q, long_d;

  assign ks = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      db_cnt_q    <= '0;
      hold_q      <= '0;
      long_done_q <= 1'b0;
      lvl_q       <= 1'b0;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      lvl_q       <= lvl_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      long_q      <= long_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_d      = hold_q;
    long_done_d = long_done_q;
    case (state_q)
      ST_IDLE: begin
        if (!ks) begin
          state_d  = ST_PRESS_DB;
          db_cnt_d = '0;
        end
      end
      ST_PRESS_DB: begin
        if (ks) begin
          state_d = ST_IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = ST_HELD;
          hold_d      = '0;
          long_done_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        // Hold timing runs even on the cycle that leaves for REL_DB.
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end else begin
          long_done_d = 1'b1;
        end
        if (ks) begin
          state_d  = ST_REL_DB;
          db_cnt_d = '0;
        end
      end
      ST_REL_DB: begin
        if (!ks) begin
          state_d = ST_HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = ST_IDLE;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    press_d = (state_q == ST_PRESS_DB) && (state_d == ST_HELD);
    rel_d   = (state_q == ST_REL_DB) && (state_d == ST_IDLE);
    long_d  = (state_q == ST_HELD) && (hold_q == HOLD_LAST) && !long_done_q;
    lvl_d   = (state_d == ST_HELD) || (state_d == ST_REL_DB);
  end

  assign state_o     = lvl_q;
  assign press_o     = press_q;
  assign release_o   = rel_q;
  assign long_o      = long_q;
  assign press_nxt_o = press_d;

endmodule

`default_nettype wire

// File: rtl/key_debounce.sv
// +----------------------------------------------------------------------+
// | key_debounce: NUM_KEYS independent debounced key channels with a     |
// | registered lowest-index press encoder.                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS    = 4,
  parameter int unsigned CLK_FREQ_HZ = 25_000_000,
  parameter int unsigned DEBOUNCE_US = 20_000,
  parameter int unsigned LONG_US     = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic                key_valid,
  output logic [2:0]          key_code
);

  localparam int unsigned DEBOUNCE_CYC = us_to_cycles(CLK_FREQ_HZ, DEBOUNCE_US);
  localparam int unsigned LONG_CYC     = us_to_cycles(CLK_FREQ_HZ, LONG_US);

  logic [NUM_KEYS-1:0] press_nxt;
  logic                valid_q, valid_d;
  logic [2:0]          code_q, code_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
      key_debounce_ch #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .LONG_CYC     (LONG_CYC)
      ) u_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n_i     (key_n[gi]),
        .state_o     (key_state[gi]),
        .press_o     (key_press[gi]),
        .release_o   (key_release[gi]),
        .long_o      (key_long[gi]),
        .press_nxt_o (press_nxt[gi])
      );
    end
  endgenerate

  // Encoded from next-cycle press so valid/code stay aligned with key_press.
  always_comb begin
    valid_d = |press_nxt;
    code_d  = 3'd0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (press_nxt[i]) begin
        code_d = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      code_q  <= 3'd0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  assign key_valid = valid_q;
  assign key_code  = code_q;

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
// +----------------------------------------------------------------------+
// | tb_key_debounce: directed vector table plus a reset sequence for     |
// | key_debounce at 1 MHz, 8 us debounce, 40 us long press.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic [3:0] key_state, key_press, key_release, key_long;
  logic       key_valid;
  logic [2:0] key_code;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [3:0] kn;
    int         cyc;
    logic [3:0] st;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] lg;
    logic       vld;
    logic [2:0] code;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] seen;
  int         press_edge;
  int         n_press;
  int         n_rel;

  key_debounce #(
    .NUM_KEYS    (4),
    .CLK_FREQ_HZ (1_000_000),
    .DEBOUNCE_US (8),
    .LONG_US     (40)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n       (key_n),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .key_valid   (key_valid),
    .key_code    (key_code)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] outs();
    return {key_state, key_press, key_release, key_long, key_valid, key_code};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input string n, input logic [3:0] kn, input int cyc,
                              input logic [3:0] st, input logic [3:0] pr,
                              input logic [3:0] rl, input logic [3:0] lg,
                              input logic vld, input logic [2:0] code);
    vec_t v;
    v.name = n; v.kn = kn; v.cyc = cyc; v.st = st; v.pr = pr;
    v.rl = rl; v.lg = lg; v.vld = vld; v.code = code;
    vecs.push_back(v);
  endfunction

  initial begin
    // Each record: drive kn, advance cyc edges, compare outputs after the last.
    add("A_wait",       4'hE, 10, 4'h1 & 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    add("A_press",      4'hE,  1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 3'd0);
    add("A_after",      4'hE,  1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    add("A_glitch",     4'hF,  3, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    add("A_glitch_end", 4'hE,  5, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    add("A_rel_wait",   4'hF, 10, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    add("A_release",    4'hF,  1, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 3'd0);
    add("A_idle",       4'hF,  1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    for (int r = 0; r < 3; r++) begin
      add("B_low",      4'hD,  5, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
      add("B_high",     4'hF,  5, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    end
    add("C_wait",       4'hB, 10, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    add("C_press",      4'hB,  1, 4'h4, 4'h4, 4'h0, 4'h0, 1'b1, 3'd2);
    add("C_hold",       4'hB, 39, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    add("C_long",       4'hB,  1, 4'h4, 4'h0, 4'h0, 4'h4, 1'b0, 3'd0);
    add("C_hold2",      4'hB,  9, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    add("C_rel_wait",   4'hF, 10, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    add("C_release",    4'hF,  1, 4'h0, 4'h0, 4'h4, 4'h0, 1'b0, 3'd0);
    add("C_idle",       4'hF,  1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    add("D_wait",       4'h5, 10, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    add("D_press",      4'h5,  1, 4'hA, 4'hA, 4'h0, 4'h0, 1'b1, 3'd1);
    add("D_after",      4'h5,  1, 4'hA, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    add("D_rel_wait",   4'hF, 10, 4'hA, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    add("D_release",    4'hF,  1, 4'h0, 4'h0, 4'hA, 4'h0, 1'b0, 3'd0);
    add("D_idle",       4'hF,  1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    add("E_wait",       4'hE, 10, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    add("E_press",      4'hE,  1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 3'd0);
    add("E_hold",       4'hE, 37, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    add("E_rel_start",  4'hF,  2, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    add("E_long",       4'hF,  1, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0, 3'd0);
    add("E_rel_wait",   4'hF,  7, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    add("E_release",    4'hF,  1, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 3'd0);
    add("E_idle",       4'hF,  1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);

    tick();
    tick();
    check("reset_outputs", 32'(outs()), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      seen  = 4'h0;
      key_n = vecs[i].kn;
      for (int c = 0; c < vecs[i].cyc; c++) begin
        tick();
        if (c != vecs[i].cyc - 1) seen = seen | key_press | key_release | key_long;
      end
      check({vecs[i].name, "_outputs"}, 32'(outs()),
            32'({vecs[i].st, vecs[i].pr, vecs[i].rl, vecs[i].lg, vecs[i].vld, vecs[i].code}));
      if (vecs[i].cyc > 1) check({vecs[i].name, "_quiet"}, 32'(seen), 32'd0);
    end

    // Reset while key 0 is held: event discarded, then re-debounced from IDLE.
    key_n = 4'hE;
    repeat (13) tick();
    check("R_held", 32'(key_state), 32'h1);
    rst_n = 1'b0;
    #1;
    check("R_async", 32'(outs()), 32'd0);
    repeat (3) tick();
    check("R_during", 32'(outs()), 32'd0);
    rst_n      = 1'b1;
    press_edge = -1;
    n_press    = 0;
    n_rel      = 0;
    for (int e = 0; e < 14; e++) begin
      tick();
      if (key_press[0]) begin
        n_press++;
        if (press_edge < 0) press_edge = e;
      end
      if (key_release != 4'h0) n_rel++;
    end
    check("R_press_edge", 32'(press_edge), 32'd10);
    check("R_press_count", 32'(n_press), 32'd1);
    check("R_no_release", 32'(n_rel), 32'd0);
    check("R_state", 32'(key_state), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
